// File: rtl/xunit_msched_pkg.sv
// Shared types and constants for the SHA-2 message-schedule unit.
// Holds the FSM encoding, block size and the sigma rotate/shift amounts for both word widths.
package xunit_msched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_LOAD   = 2'd2,
    ST_EXPAND = 2'd3
  } state_t;

  localparam int BLOCK_WORDS = 16;

  // Rotate/shift amounts: sigma0 = ROTR r1 ^ ROTR r2 ^ SHR sh, likewise for sigma1.
  typedef struct packed {
    int s0_r1;
    int s0_r2;
    int s0_sh;
    int s1_r1;
    int s1_r2;
    int s1_sh;
  } sigma_cfg_t;

  localparam sigma_cfg_t SIGMA_256 = '{7, 18, 3, 17, 19, 10};
  localparam sigma_cfg_t SIGMA_512 = '{1, 8, 7, 19, 61, 6};

  function automatic sigma_cfg_t sigma_cfg(input int data_w);
    return (data_w == 64) ? SIGMA_512 : SIGMA_256;
  endfunction

endpackage

// File: rtl/xunit_sigma.sv
// Combinational SHA-2 small sigma functions: sigma0 of x0 and sigma1 of x1.
// DATA_W selects the SHA-256 (32) or SHA-512 (64) constant set; other widths do not elaborate.
module xunit_sigma
  import xunit_msched_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] x0,
  input  logic [DATA_W-1:0] x1,
  output logic [DATA_W-1:0] sigma0,
  output logic [DATA_W-1:0] sigma1
);

  localparam sigma_cfg_t CFG = sigma_cfg(DATA_W);

  generate
    if (DATA_W != 32 && DATA_W != 64) begin : g_bad_width
      $error("xunit_sigma: DATA_W must be 32 or 64");
    end
  endgenerate

  function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x, input int n);
    return (x >> n) | (x << (DATA_W - n));
  endfunction

  assign sigma0 = rotr(x0, CFG.s0_r1) ^ rotr(x0, CFG.s0_r2) ^ (x0 >> CFG.s0_sh);
  assign sigma1 = rotr(x1, CFG.s1_r1) ^ rotr(x1, CFG.s1_r2) ^ (x1 >> CFG.s1_sh);

endmodule

// File: rtl/xunit_msched.sv
// SHA-2 message-schedule unit: loads one 16-word block after a run pulse and optional delay,
// then streams W[16..16*(B+1)-1] with its own valid and done indications.
module xunit_msched
  import xunit_msched_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int DELAY_W = 8,
  parameter int BLK_W   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic [DELAY_W-1:0] delay0,
  input  logic [BLK_W-1:0]   blocks0,
  input  logic [DATA_W-1:0]  in0,
  output logic [DATA_W-1:0]  out0,
  output logic               valid0,
  output logic               done,
  output logic [1:0]         state_dbg
);

  // Output stream: out0 carries a word in every cycle valid0 is high; there is no ready,
  // so the consumer must accept each valid word in the cycle it appears.

  localparam int CNT_W = BLK_W + 4;

  state_t               state;
  logic                 rst_q;
  logic                 run_ok;
  logic [DELAY_W-1:0]   wait_cnt;
  logic [BLK_W-1:0]     blocks;
  logic [3:0]           load_cnt;
  logic [CNT_W-1:0]     out_cnt;
  logic [CNT_W-1:0]     out_total;
  logic [DATA_W-1:0]    win [BLOCK_WORDS];
  logic [DATA_W-1:0]    sig0;
  logic [DATA_W-1:0]    sig1;
  logic [DATA_W-1:0]    w_new;

  // Reset release is retimed by one flop so run is only honoured from the second edge on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_q <= 1'b0;
    else        rst_q <= 1'b1;
  end

  assign run_ok    = run & rst_q;
  assign out_total = {blocks, 4'b0000};
  assign state_dbg = state;

  // win[15] is W[t-1], win[0] is W[t-16].
  xunit_sigma #(.DATA_W(DATA_W)) u_sigma (
    .x0     (win[1]),
    .x1     (win[14]),
    .sigma0 (sig0),
    .sigma1 (sig1)
  );

  assign w_new = sig1 + win[9] + sig0 + win[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      blocks   <= BLK_W'(1);
      load_cnt <= '0;
      out_cnt  <= '0;
      out0     <= '0;
      valid0   <= 1'b0;
      done     <= 1'b0;
      for (int i = 0; i < BLOCK_WORDS; i++) win[i] <= '0;
    end else if (run_ok) begin
      // A run from any state restarts with the new configuration.
      blocks   <= (blocks0 == '0) ? BLK_W'(1) : blocks0;
      wait_cnt <= delay0 - 1'b1;
      load_cnt <= '0;
      out_cnt  <= '0;
      valid0   <= 1'b0;
      done     <= 1'b0;
      state    <= (delay0 != '0) ? ST_WAIT : ST_LOAD;
    end else begin
      case (state)
        ST_IDLE: begin
          valid0 <= 1'b0;
        end
        ST_WAIT: begin
          if (wait_cnt == '0) state <= ST_LOAD;
          else                wait_cnt <= wait_cnt - 1'b1;
        end
        ST_LOAD: begin
          for (int i = 0; i < BLOCK_WORDS - 1; i++) win[i] <= win[i+1];
          win[BLOCK_WORDS-1] <= in0;
          load_cnt <= load_cnt + 1'b1;
          if (load_cnt == 4'(BLOCK_WORDS - 1)) state <= ST_EXPAND;
        end
        ST_EXPAND: begin
          // One extra cycle after the last word drops valid0 and raises done together.
          if (out_cnt == out_total) begin
            valid0 <= 1'b0;
            done   <= 1'b1;
            state  <= ST_IDLE;
          end else begin
            for (int i = 0; i < BLOCK_WORDS - 1; i++) win[i] <= win[i+1];
            win[BLOCK_WORDS-1] <= w_new;
            out0    <= w_new;
            valid0  <= 1'b1;
            out_cnt <= out_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xunit_msched.sv
// Bench for xunit_msched: a 32-bit and a 64-bit instance checked against an array-based
// SHA-2 schedule model plus known-answer words.
module tb_xunit_msched;
  import xunit_msched_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run_a = 1'b0;
  logic        run_b = 1'b0;
  logic [7:0]  delay_cfg = '0;
  logic [2:0]  blocks_cfg = '0;
  logic [63:0] in_bus = '0;

  logic [31:0] out_a;
  logic        valid_a, done_a;
  logic [1:0]  st_a;
  logic [63:0] out_b;
  logic        valid_b, done_b;
  logic [1:0]  st_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];
  logic [63:0] blk[16];

  // Clock and reset
  always #5 clk = ~clk;

  xunit_msched #(.DATA_W(32), .DELAY_W(8), .BLK_W(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .run(run_a), .delay0(delay_cfg), .blocks0(blocks_cfg),
    .in0(in_bus[31:0]), .out0(out_a), .valid0(valid_a), .done(done_a), .state_dbg(st_a)
  );

  xunit_msched #(.DATA_W(64), .DELAY_W(8), .BLK_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .run(run_b), .delay0(delay_cfg), .blocks0(blocks_cfg),
    .in0(in_bus), .out0(out_b), .valid0(valid_b), .done(done_b), .state_dbg(st_b)
  );

  function automatic logic obs_valid(input bit sel);
    return sel ? valid_b : valid_a;
  endfunction

  function automatic logic obs_done(input bit sel);
    return sel ? done_b : done_a;
  endfunction

  function automatic logic [63:0] obs_out(input bit sel);
    return sel ? out_b : {32'h0, out_a};
  endfunction

  // Reference model: SHA-2 schedule recurrence over a plain array
  function automatic logic [63:0] m_mask(input int w);
    return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  function automatic logic [63:0] m_rotr(input logic [63:0] x, input int n, input int w);
    return ((x >> n) | (x << (w - n))) & m_mask(w);
  endfunction

  function automatic logic [63:0] m_sig0(input logic [63:0] x, input int w);
    if (w == 32) return m_rotr(x, 7, 32) ^ m_rotr(x, 18, 32) ^ (x >> 3);
    return m_rotr(x, 1, 64) ^ m_rotr(x, 8, 64) ^ (x >> 7);
  endfunction

  function automatic logic [63:0] m_sig1(input logic [63:0] x, input int w);
    if (w == 32) return m_rotr(x, 17, 32) ^ m_rotr(x, 19, 32) ^ (x >> 10);
    return m_rotr(x, 19, 64) ^ m_rotr(x, 61, 64) ^ (x >> 6);
  endfunction

  task automatic model_fill(input bit sel, input int b);
    int w;
    int nb;
    logic [63:0] sched[128];
    w  = sel ? 64 : 32;
    nb = (b == 0) ? 1 : b;
    exp_q.delete();
    for (int t = 0; t < 16; t++) sched[t] = blk[t] & m_mask(w);
    for (int t = 16; t < 16 + 16 * nb; t++) begin
      sched[t] = (m_sig1(sched[t-2], w) + sched[t-7] + m_sig0(sched[t-15], w) + sched[t-16])
                 & m_mask(w);
      exp_q.push_back(sched[t]);
    end
  endtask

  // Drivers
  task automatic pulse_run(input bit sel, input int d, input int b);
    delay_cfg  = 8'(d);
    blocks_cfg = 3'(b);
    if (sel) run_b = 1'b1;
    else     run_a = 1'b1;
    @(negedge clk);
    run_a = 1'b0;
    run_b = 1'b0;
  endtask

  // Called one negedge after the run edge; feeds blk and scoreboards every output word.
  // Returns right after output stop_j when stop_j >= 0, otherwise after checking done.
  task automatic feed_and_check(input bit sel, input int d, input int b, input int stop_j,
                                input string tag);
    int nb;
    logic [63:0] exp;
    nb = (b == 0) ? 1 : b;
    model_fill(sel, b);
    got_q.delete();
    for (int i = 0; i < d + 16; i++) begin
      in_bus = (i < d) ? {$urandom, $urandom} : blk[i-d];
      n_checks++;
      if (obs_valid(sel) !== 1'b0 || obs_done(sel) !== 1'b0) begin
        n_fail++;
        $display("FAIL %s pre-output cycle %0d: valid=%0b done=%0b, want valid=0 done=0",
                 tag, i, obs_valid(sel), obs_done(sel));
      end
      @(negedge clk);
    end
    in_bus = {$urandom, $urandom};
    n_checks++;
    if (obs_valid(sel) !== 1'b0) begin
      n_fail++;
      $display("FAIL %s latency: valid=1 at %0d cycles after run, want first valid at %0d",
               tag, d + 16, d + 17);
    end
    for (int j = 0; j < 16 * nb; j++) begin
      @(negedge clk);
      in_bus = {$urandom, $urandom};
      exp = exp_q.pop_front();
      got_q.push_back(obs_out(sel));
      n_checks++;
      if (obs_valid(sel) !== 1'b1 || obs_out(sel) !== exp || obs_done(sel) !== 1'b0) begin
        n_fail++;
        $display("FAIL %s out[%0d]: got valid=%0b done=%0b data=%h, want valid=1 done=0 data=%h",
                 tag, j, obs_valid(sel), obs_done(sel), obs_out(sel), exp);
      end
      if (j == stop_j) return;
    end
    @(negedge clk);
    n_checks++;
    if (obs_valid(sel) !== 1'b0 || obs_done(sel) !== 1'b1) begin
      n_fail++;
      $display("FAIL %s end: got valid=%0b done=%0b, want valid=0 done=1",
               tag, obs_valid(sel), obs_done(sel));
    end
  endtask

  task automatic set_abc_256();
    for (int k = 0; k < 16; k++) blk[k] = '0;
    blk[0]  = 64'h6162_6380;
    blk[15] = 64'h18;
  endtask

  task automatic set_random_blk();
    for (int k = 0; k < 16; k++) blk[k] = {$urandom, $urandom};
  endtask

  task automatic check_word(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", tag, got, want);
    end
  endtask

  // Scenarios
  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      run_a  = i[0];
      run_b  = ~i[0];
      in_bus = {$urandom, $urandom};
      #1;
      n_checks++;
      if (out_a !== '0 || valid_a !== 1'b0 || done_a !== 1'b0 ||
          out_b !== '0 || valid_b !== 1'b0 || done_b !== 1'b0 ||
          st_a !== 2'(ST_IDLE) || st_b !== 2'(ST_IDLE)) begin
        n_fail++;
        $display("FAIL reset_hold: a=%h/%0b/%0b b=%h/%0b/%0b st=%0d/%0d, want all zero, IDLE",
                 out_a, valid_a, done_a, out_b, valid_b, done_b, st_a, st_b);
      end
    end
    @(negedge clk);
    // run held through the first edge after release must be ignored.
    delay_cfg  = '0;
    blocks_cfg = 3'd1;
    rst_n = 1'b1;
    run_a = 1'b1;
    run_b = 1'b1;
    @(negedge clk);
    run_a = 1'b0;
    run_b = 1'b0;
    for (int i = 0; i < 22; i++) begin
      n_checks++;
      if (out_a !== '0 || valid_a !== 1'b0 || done_a !== 1'b0 ||
          out_b !== '0 || valid_b !== 1'b0 || done_b !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_release cycle %0d: a=%h/%0b/%0b b=%h/%0b/%0b, want all zero",
                 i, out_a, valid_a, done_a, out_b, valid_b, done_b);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_abc();
    set_abc_256();
    pulse_run(1'b0, 0, 1);
    feed_and_check(1'b0, 0, 1, -1, "abc_b1");
    check_word("abc_w16", got_q[0], 64'h6162_6380);
    check_word("abc_w17", got_q[1], 64'h000F_0000);
    check_word("abc_w18", got_q[2], 64'h7DA8_6405);
    check_word("abc_count", 64'(got_q.size()), 64'd16);
  endtask

  task automatic test_abc_multi();
    set_abc_256();
    pulse_run(1'b0, 0, 3);
    feed_and_check(1'b0, 0, 3, -1, "abc_b3");
    check_word("abc_count_b3", 64'(got_q.size()), 64'd48);
    check_word("abc_w63", got_q[47], 64'h12B1_EDEB);
  endtask

  task automatic test_delay();
    set_abc_256();
    pulse_run(1'b0, 5, 1);
    feed_and_check(1'b0, 5, 1, -1, "abc_d5");
    check_word("abc_d5_w18", got_q[2], 64'h7DA8_6405);
  endtask

  task automatic test_restart();
    set_random_blk();
    pulse_run(1'b0, 0, 1);
    feed_and_check(1'b0, 0, 1, 4, "pre_restart");
    set_random_blk();
    pulse_run(1'b0, 2, 2);
    n_checks++;
    if (valid_a !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_drop: valid=%0b, want 0", valid_a);
    end
    feed_and_check(1'b0, 2, 2, -1, "post_restart");
  endtask

  task automatic test_random();
    bit sel;
    int d, b;
    for (int i = 0; i < 8; i++) begin
      sel = 1'($urandom_range(0, 1));
      d   = $urandom_range(0, 12);
      b   = $urandom_range(0, 7);
      if (i == 6) begin sel = 1'b0; d = 255; b = 7; end
      if (i == 7) begin sel = 1'b1; d = 0;   b = 0; end
      set_random_blk();
      pulse_run(sel, d, b);
      feed_and_check(sel, d, b, -1, $sformatf("rand%0d_w%0d_d%0d_b%0d", i, sel ? 64 : 32, d, b));
    end
  endtask

  task automatic test_reset_mid();
    set_random_blk();
    pulse_run(1'b0, 0, 2);
    feed_and_check(1'b0, 0, 2, 3, "pre_reset");
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_a !== '0 || valid_a !== 1'b0 || done_a !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_async: out=%h valid=%0b done=%0b, want 0/0/0",
               out_a, valid_a, done_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      n_checks++;
      if (valid_a !== 1'b0 || done_a !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_mid_after cycle %0d: valid=%0b done=%0b, want 0/0",
                 i, valid_a, done_a);
      end
    end
  endtask

  task automatic test_sha512();
    for (int k = 0; k < 16; k++) blk[k] = '0;
    blk[0]  = 64'h6162_6380_0000_0000;
    blk[15] = 64'h18;
    pulse_run(1'b1, 0, 1);
    feed_and_check(1'b1, 0, 1, -1, "sha512_b1");
    check_word("sha512_w16", got_q[0], 64'h6162_6380_0000_0000);
    check_word("sha512_w17", got_q[1], 64'h0003_0000_0000_00C0);
  endtask

  initial begin
    test_reset();
    test_abc();
    test_abc_multi();
    test_delay();
    test_restart();
    test_random();
    test_reset_mid();
    test_sha512();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
